// File: rtl/display_flip_ctrl_pkg.sv
// Shared definitions for the display page-flip controller: state encoding,
// default framebuffer addresses and field widths.
package disp_pkg;

    localparam int ADDR_W = 30;
    localparam int WD_W   = 24;
    localparam int FCNT_W = 16;

    localparam logic [ADDR_W-1:0] FB0_ADDR_DEF  = 30'h10a64580;
    localparam logic [ADDR_W-1:0] FB1_ADDR_DEF  = 30'h10b64580;
    localparam logic [WD_W-1:0]   TO_CYCLES_DEF = 24'd2000000;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        WAIT_VB = 3'd1,
        CLEAR   = 3'd2,
        RUN     = 3'd3,
        PEND    = 3'd4
    } flip_state_e;

    function automatic logic [ADDR_W-1:0] fb_addr(
        input logic              sel,
        input logic [ADDR_W-1:0] fb0,
        input logic [ADDR_W-1:0] fb1
    );
        return sel ? fb1 : fb0;
    endfunction

endpackage

// File: rtl/display_flip_ctrl_if.sv
// Renderer/display-core signal bundle of the page-flip controller.
// master = environment (display core + renderer), slave = controller.
interface display_flip_ctrl_if;

    logic                        enable;
    logic                        VBLANK;
    logic                        flip_req;
    logic                        CLRVBLNK;
    logic [disp_pkg::ADDR_W-1:0] DISPADDR;
    logic                        DISPON;
    logic                        flip_ack;
    logic [disp_pkg::ADDR_W-1:0] back_addr;
    logic [disp_pkg::FCNT_W-1:0] frame_cnt;
    logic                        vb_timeout;
    logic [2:0]                  state;

    modport master (
        output enable, VBLANK, flip_req,
        input  CLRVBLNK, DISPADDR, DISPON, flip_ack, back_addr,
               frame_cnt, vb_timeout, state
    );

    modport slave (
        input  enable, VBLANK, flip_req,
        output CLRVBLNK, DISPADDR, DISPON, flip_ack, back_addr,
               frame_cnt, vb_timeout, state
    );

endinterface

// File: rtl/display_flip_ctrl_vblank_watchdog.sv
// Saturating VBLANK watchdog: counts active cycles up to a limit and raises a
// sticky flag when the limit is reached.
module vblank_watchdog #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_flag_clr,
    input  logic [W-1:0] i_limit,
    output logic         o_timeout
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic         r_flag;

    // NOTE: every always_comb output is assigned a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_en && (r_cnt != i_limit)) begin
            w_cnt_nxt = r_cnt + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (i_flag_clr) begin
                r_flag <= 1'b0;
            end else if (i_en && (w_cnt_nxt == i_limit)) begin
                r_flag <= 1'b1;
            end
        end
    end

    assign o_timeout = r_flag;

endmodule

// File: rtl/display_flip_ctrl.sv
// Double-buffer page-flip controller: brings the display up on the first
// VBLANK, then swaps front/back framebuffers only inside VBLANK on request.
module display_flip_ctrl
    import disp_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB0_ADDR  = FB0_ADDR_DEF,
    parameter logic [ADDR_W-1:0] FB1_ADDR  = FB1_ADDR_DEF,
    parameter logic [WD_W-1:0]   TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    display_flip_ctrl_if.slave bus
);

    flip_state_e       r_state,     w_state_nxt;
    logic              r_clr,       w_clr_nxt;
    logic [ADDR_W-1:0] r_dispaddr,  w_dispaddr_nxt;
    logic              r_dispon,    w_dispon_nxt;
    logic              r_ack,       w_ack_nxt;
    logic [FCNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic              r_front_sel, w_front_sel_nxt;

    logic              w_do_flip;
    logic              w_wd_clr;
    logic              w_wd_en;
    logic              w_flag_clr;
    logic              w_vb_timeout;
    logic [ADDR_W-1:0] w_front_addr;
    logic [ADDR_W-1:0] w_back_addr;

    assign w_front_addr = fb_addr(r_front_sel, FB0_ADDR, FB1_ADDR);
    assign w_back_addr  = fb_addr(~r_front_sel, FB0_ADDR, FB1_ADDR);

    always_comb begin
        w_state_nxt     = r_state;
        w_clr_nxt       = r_clr;
        w_dispaddr_nxt  = r_dispaddr;
        w_dispon_nxt    = r_dispon;
        w_ack_nxt       = r_ack;
        w_frame_cnt_nxt = r_frame_cnt;
        w_front_sel_nxt = r_front_sel;
        w_do_flip       = 1'b0;
        w_wd_clr        = 1'b0;
        w_wd_en         = 1'b0;
        w_flag_clr      = 1'b0;

        case (r_state)
            INIT: begin
                w_clr_nxt   = 1'b0;
                w_flag_clr  = 1'b1;
                w_state_nxt = WAIT_VB;
            end
            WAIT_VB: begin
                if (bus.enable && bus.VBLANK) begin
                    w_dispaddr_nxt = w_front_addr;
                    w_dispon_nxt   = 1'b1;
                    w_clr_nxt      = 1'b1;
                    w_state_nxt    = CLEAR;
                end
            end
            CLEAR: begin
                // flip_req is deliberately not looked at here: the requester is still dropping it after an ack
                w_clr_nxt   = 1'b0;
                w_ack_nxt   = 1'b0;
                w_wd_clr    = 1'b1;
                w_state_nxt = RUN;
            end
            RUN, PEND: begin
                w_wd_en = 1'b1;
                if (!bus.enable) begin
                    w_dispon_nxt = 1'b0;
                    w_flag_clr   = 1'b1;
                    w_state_nxt  = WAIT_VB;
                end else if (bus.VBLANK && (bus.flip_req || (r_state == PEND))) begin
                    w_do_flip = 1'b1;
                end else if (bus.VBLANK) begin
                    w_clr_nxt       = 1'b1;
                    w_frame_cnt_nxt = r_frame_cnt + FCNT_W'(1);
                    w_state_nxt     = CLEAR;
                end else if (bus.flip_req) begin
                    w_state_nxt = PEND;
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase

        if (w_do_flip) begin
            w_front_sel_nxt = ~r_front_sel;
            w_dispaddr_nxt  = w_back_addr;
            w_ack_nxt       = 1'b1;
            w_clr_nxt       = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + FCNT_W'(1);
            w_state_nxt     = CLEAR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= INIT;
            r_clr       <= 1'b1;
            r_dispaddr  <= '0;
            r_dispon    <= 1'b0;
            r_ack       <= 1'b0;
            r_frame_cnt <= '0;
            r_front_sel <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr       <= w_clr_nxt;
            r_dispaddr  <= w_dispaddr_nxt;
            r_dispon    <= w_dispon_nxt;
            r_ack       <= w_ack_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_front_sel <= w_front_sel_nxt;
        end
    end

    vblank_watchdog #(
        .W (WD_W)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_wd_clr),
        .i_en       (w_wd_en),
        .i_flag_clr (w_flag_clr),
        .i_limit    (TO_CYCLES),
        .o_timeout  (w_vb_timeout)
    );

    assign bus.CLRVBLNK   = r_clr;
    assign bus.DISPADDR   = r_dispaddr;
    assign bus.DISPON     = r_dispon;
    assign bus.flip_ack   = r_ack;
    assign bus.back_addr  = w_back_addr;
    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.vb_timeout = w_vb_timeout;
    assign bus.state      = r_state;

endmodule
